mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, consecutive D wins over a pending I request before I is forced priority.
REQ-002 Parameter: LINE_W, default 128, cache-line width in bits.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 i_pmem_read  in  1  I-cache line-fill request.
REQ-007 i_pmem_address  in  16  I-cache line address.
REQ-008 i_pmem_rdata  out  LINE_W  fill data to the I-cache.
REQ-009 i_pmem_resp  out  1  I-cache transaction done.
REQ-010 d_pmem_read  in  1  D-cache line-fill request.
REQ-011 d_pmem_write  in  1  D-cache writeback request.
REQ-012 d_pmem_address  in  16  D-cache line address.
REQ-013 d_pmem_wdata  in  LINE_W  D-cache writeback data.
REQ-014 d_pmem_rdata  out  LINE_W  fill data to the D-cache.
REQ-015 d_pmem_resp  out  1  D-cache transaction done.
REQ-016 pmem_read, pmem_write  out  1 each  physical memory command.
REQ-017 pmem_address  out  16; pmem_wdata  out  LINE_W; pmem_rdata  in  LINE_W; pmem_resp  in  1  physical memory port.
REQ-018 busy  out  1  transaction in flight; owner  out  1  0=I, 1=D (valid while busy).

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, SERVE_I, SERVE_D.
REQ-020 In IDLE with only one requester active, the FSM SHALL enter that requester's SERVE state at the next edge.
REQ-021 In IDLE with both requesters active, D SHALL win unless starve_cnt == STARVE_LIMIT, in which case I SHALL win.
REQ-022 starve_cnt SHALL increment, saturating at STARVE_LIMIT, on each D grant made while i_pmem_read is high, and SHALL clear on every I grant.
REQ-023 At grant the block SHALL latch address, operation (read/write) and wdata; pmem outputs SHALL be driven only from these latches.
REQ-024 In SERVE_x, pmem_read or pmem_write SHALL be held high continuously until pmem_resp is sampled high.
REQ-025 In the pmem_resp cycle, the owner's *_resp SHALL be 1 and its *_rdata SHALL equal pmem_rdata combinationally, and the FSM SHALL return to IDLE at the next edge.
REQ-026 The non-owner's resp SHALL remain 0 at all times, and its rdata SHALL be 0.
REQ-027 Grant-to-memory latency SHALL be 1 cycle; back-to-back transactions SHALL have at least 1 IDLE cycle between them.
REQ-028 A request deasserted mid-transaction SHALL NOT abort it; the latched transaction SHALL complete and its resp SHALL still pulse.
REQ-029 d_pmem_read and d_pmem_write high together is illegal; the block SHALL treat it as a write.
REQ-030 pmem_resp sampled in IDLE SHALL be ignored: no resp forwarded, no state change.
REQ-031 pmem_read and pmem_write SHALL never be high simultaneously.

Reset
REQ-032 On reset, state SHALL become IDLE, starve_cnt 0, and all latches 0.
REQ-033 After reset, pmem_read, pmem_write, busy, owner, i_pmem_resp and d_pmem_resp SHALL all be 0, and all data and address outputs SHALL be 0.
REQ-034 Reset asserted during SERVE_x SHALL drop the pmem command at the next edge; the interrupted transaction SHALL NOT produce a resp.

Structure
REQ-035 lc3b_types SHALL hold lc3b_word, lc3b_c_line (LINE_W-bit) and the arbiter state enum lc3b_arb_state.
REQ-036 The design SHALL be a single module with no sub-modules; the starvation counter SHALL be inline.

Verification
REQ-037 I only, address 0x1230, memory resp after 3 cycles -> pmem_read for 3 cycles; i_pmem_resp pulses 1 cycle with the line; d_pmem_resp stays 0.
REQ-038 I and D reads rise in the same cycle -> D served first; I served after one IDLE cycle; starve_cnt goes 0 then 1 then 0.
REQ-039 STARVE_LIMIT=2, I held high while D re-requests continuously -> D, D, then I granted.
REQ-040 D write of 0xA5A5... to 0x4000 -> pmem_write high, pmem_wdata and pmem_address match; d_pmem_resp pulses once.
REQ-041 Reset in 2nd SERVE_D cycle, then late pmem_resp -> pmem_read drops next edge; no resp forwarded; state is IDLE.
REQ-042 D drops its request mid-transaction -> pmem command held until pmem_resp; d_pmem_resp still pulses.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-subsystem types: address word, cache line and the
// physical-memory arbiter state encoding.
package lc3b_types;

   localparam int C_LINE_W = 128;

   typedef logic [15:0]         lc3b_word;
   typedef logic [C_LINE_W-1:0] lc3b_c_line;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } lc3b_arb_state;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the I-cache and D-cache line ports onto a single physical
// memory port. D has priority unless I has been passed over STARVE_LIMIT times.
module mem_arbiter
   import lc3b_types::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int LINE_W       = 128
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              i_pmem_read,
   input  logic [15:0]       i_pmem_address,
   output logic [LINE_W-1:0] i_pmem_rdata,
   output logic              i_pmem_resp,

   input  logic              d_pmem_read,
   input  logic              d_pmem_write,
   input  logic [15:0]       d_pmem_address,
   input  logic [LINE_W-1:0] d_pmem_wdata,
   output logic [LINE_W-1:0] d_pmem_rdata,
   output logic              d_pmem_resp,

   output logic              pmem_read,
   output logic              pmem_write,
   output logic [15:0]       pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp,

   output logic              busy,
   output logic              owner
);

   localparam int            CW    = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   lc3b_arb_state     state;
   logic [CW-1:0]     starve_cnt;
   lc3b_word          addr_q;
   logic [LINE_W-1:0] wdata_q;
   logic              read_q;
   logic              write_q;

   logic d_req;
   logic i_forced;
   logic resp_ok;

   assign d_req    = d_pmem_read | d_pmem_write;
   assign i_forced = i_pmem_read && (starve_cnt == LIMIT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         starve_cnt <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         read_q     <= 1'b0;
         write_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (d_req && !i_forced) begin
                  // read+write together is treated as a writeback
                  state   <= SERVE_D;
                  addr_q  <= d_pmem_address;
                  wdata_q <= d_pmem_wdata;
                  read_q  <= ~d_pmem_write;
                  write_q <= d_pmem_write;
                  if (i_pmem_read && (starve_cnt != LIMIT))
                     starve_cnt <= starve_cnt + 1'b1;
               end else if (i_pmem_read) begin
                  state      <= SERVE_I;
                  addr_q     <= i_pmem_address;
                  wdata_q    <= '0;
                  read_q     <= 1'b1;
                  write_q    <= 1'b0;
                  starve_cnt <= '0;
               end
            end
            SERVE_I, SERVE_D: begin
               if (pmem_resp) begin
                  state   <= IDLE;
                  read_q  <= 1'b0;
                  write_q <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               read_q  <= 1'b0;
               write_q <= 1'b0;
            end
         endcase
      end
   end

   // A transaction cut short by reset never reports completion.
   assign resp_ok      = pmem_resp & ~reset;
   assign i_pmem_resp  = resp_ok & (state == SERVE_I);
   assign d_pmem_resp  = resp_ok & (state == SERVE_D);
   assign i_pmem_rdata = i_pmem_resp ? pmem_rdata : '0;
   assign d_pmem_rdata = d_pmem_resp ? pmem_rdata : '0;

   assign pmem_read    = read_q;
   assign pmem_write   = write_q;
   assign pmem_address = addr_q;
   assign pmem_wdata   = wdata_q;

   assign busy  = (state != IDLE);
   assign owner = (state == SERVE_D);

endmodule
